// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin grant/owner arbiter for the shared memory bus (optional grant watchdog: BUS_ARB_WATCHDOG_EN)
module mem_bus_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int OWNER_WIDTH   = 2,
    parameter int GRANT_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     abtr_reqcyc,
    input  logic [NUM_REQ-1:0]     bus_busy,
    output logic [NUM_REQ-1:0]     abtr_grant,
    output logic [OWNER_WIDTH-1:0] owner,
    output logic                   owner_valid,
    output logic                   grant_timeout
);

    // Requester map: 0 TLB walker, 1 ICache, 2 DCache, 3 store data.

    // A mismatched owner width or a zero timeout would make the owner index
    // and the watchdog compare meaningless, so refuse to elaborate.
    generate
        if ((OWNER_WIDTH != $clog2(NUM_REQ)) || (GRANT_TIMEOUT < 1)) begin : g_cfg_check
            $error("mem_bus_arbiter: OWNER_WIDTH must be clog2(NUM_REQ) and GRANT_TIMEOUT >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_OWNED = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [OWNER_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [OWNER_WIDTH-1:0] owner_q, owner_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic                   timeout_q, timeout_d;

    logic [OWNER_WIDTH-1:0] winner;
    logic                   winner_found;
    logic [OWNER_WIDTH-1:0] cand;
    logic [OWNER_WIDTH-1:0] owner_next;
    logic                   owner_busy;
    logic                   owner_req;
    logic                   wd_expired;

    // Index a + b folded back into 0..NUM_REQ-1; b never exceeds NUM_REQ-1.
    function automatic logic [OWNER_WIDTH-1:0] wrap_add(
        input logic [OWNER_WIDTH-1:0] a,
        input int unsigned            b
    );
        int unsigned s;
        s = 32'(a) + b;
        if (s >= 32'(NUM_REQ)) begin
            s = s - 32'(NUM_REQ);
        end
        return OWNER_WIDTH'(s);
    endfunction

    // Only the current owner's busy/request bits matter; the rest are ignored.
    assign owner_busy = bus_busy[owner_q];
    assign owner_req  = abtr_reqcyc[owner_q];
    assign owner_next = wrap_add(owner_q, 32'd1);

    // Pick the first requester at or after rr_ptr; scanning from the far end
    // lets the nearest hit overwrite the others.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        cand         = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = wrap_add(rr_ptr_q, 32'(i));
            if (abtr_reqcyc[cand]) begin
                winner       = cand;
                winner_found = 1'b1;
            end
        end
    end

`ifdef BUS_ARB_WATCHDOG_EN
    localparam int WD_WIDTH = $clog2(GRANT_TIMEOUT + 1);

    logic [WD_WIDTH-1:0] wd_cnt_q, wd_cnt_d;

    // Expires on the GRANT_TIMEOUT-th unclaimed GRANT cycle.
    assign wd_expired = (state_q == ST_GRANT) &&
                        (wd_cnt_q == WD_WIDTH'(GRANT_TIMEOUT - 1));

    // Count unclaimed GRANT cycles; held at zero outside GRANT so every new
    // grant starts fresh, and saturates instead of wrapping.
    always_comb begin
        wd_cnt_d = '0;
        if ((state_q == ST_GRANT) && !owner_busy) begin
            if (wd_cnt_q == '1) begin
                wd_cnt_d = wd_cnt_q;
            end else begin
                wd_cnt_d = wd_cnt_q + WD_WIDTH'(1);
            end
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    // Without the watchdog a grant waits for a claim or an abandon forever.
    assign wd_expired = 1'b0;
`endif

    // Next-state logic: grant issue, claim, abandon/timeout and release.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (winner_found) begin
                    state_d         = ST_GRANT;
                    owner_d         = winner;
                    grant_d[winner] = 1'b1;
                end
            end
            ST_GRANT: begin
                // A claim wins over a request dropped in the same cycle.
                if (owner_busy) begin
                    state_d = ST_OWNED;
                    grant_d = '0;
                end else if (!owner_req || wd_expired) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    rr_ptr_d  = owner_next;
                    // An abandon in the expiry cycle is not reported as a timeout.
                    timeout_d = owner_req;
                end
            end
            ST_OWNED: begin
                grant_d = '0;
                if (!owner_busy) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = owner_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, pointer, owner, grant and timeout-pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
        end
    end

    assign abtr_grant    = grant_q;
    assign owner_valid   = (state_q != ST_IDLE);
    assign owner         = owner_valid ? owner_q : '0;
    assign grant_timeout = timeout_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(abtr_grant));

    a_grant_only_in_grant: assert property (@(posedge clk) disable iff (!reset)
        (abtr_grant != '0) |-> (state_q == ST_GRANT));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter with random transactions and a round-robin reference model
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int OWNER_WIDTH   = 2;
    localparam int GRANT_TIMEOUT = 15;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [NUM_REQ-1:0]     abtr_reqcyc = '0;
    logic [NUM_REQ-1:0]     bus_busy = '0;
    logic [NUM_REQ-1:0]     abtr_grant;
    logic [OWNER_WIDTH-1:0] owner;
    logic                   owner_valid;
    logic                   grant_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int m_ptr = 0;
    int mon_e;
    logic [NUM_REQ-1:0] prev_grant = '0;

    mem_bus_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .OWNER_WIDTH  (OWNER_WIDTH),
        .GRANT_TIMEOUT(GRANT_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .abtr_reqcyc  (abtr_reqcyc),
        .bus_busy     (bus_busy),
        .abtr_grant   (abtr_grant),
        .owner        (owner),
        .owner_valid  (owner_valid),
        .grant_timeout(grant_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference rule: first requester at or after the pointer, wrapping.
    function automatic int pick(input logic [NUM_REQ-1:0] m, input int p);
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx = (p + i) % NUM_REQ;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Predict the winner for the mask about to be sampled in IDLE and wait for it.
    task automatic expect_grant(output int w);
        int n;
        w = pick(abtr_reqcyc, m_ptr);
        exp_q.push_back(w);
        n = 0;
        while ((n < 20) && (abtr_grant == '0)) begin
            step();
            n++;
        end
        check("grant_latency", n, 1);
    endtask

    task automatic claim(input int w, input int dly, input int hold, input logic [NUM_REQ-1:0] next_mask);
        logic [NUM_REQ-1:0] wb;
        wb = NUM_REQ'(1 << w);
        repeat (dly) begin
            bus_busy = NUM_REQ'($urandom) & ~wb;
            step();
            check("grant_held", abtr_grant, wb);
        end
        bus_busy = NUM_REQ'($urandom) | wb;
        step();
        check("owned_grant_low", abtr_grant, 0);
        check("owned_owner", owner, w);
        check("owned_valid", owner_valid, 1);
        for (int i = 1; i < hold; i++) begin
            bus_busy    = NUM_REQ'($urandom) | wb;
            abtr_reqcyc = NUM_REQ'($urandom);
            step();
            check("owned_hold", owner, w);
        end
        bus_busy    = NUM_REQ'($urandom) & ~wb;
        abtr_reqcyc = next_mask;
        m_ptr       = (w + 1) % NUM_REQ;
        step();
        check("release_idle", owner_valid, 0);
        check("release_grant_low", abtr_grant, 0);
        bus_busy = '0;
    endtask

    task automatic abandon(input int w, input int dly, input logic [NUM_REQ-1:0] keep);
        logic [NUM_REQ-1:0] wb;
        wb = NUM_REQ'(1 << w);
        repeat (dly) begin
            bus_busy = NUM_REQ'($urandom) & ~wb;
            step();
            check("grant_held", abtr_grant, wb);
        end
        abtr_reqcyc = keep & ~wb;
        bus_busy    = NUM_REQ'($urandom) & ~wb;
        m_ptr       = (w + 1) % NUM_REQ;
        step();
        check("abandon_idle", owner_valid, 0);
        check("abandon_grant_low", abtr_grant, 0);
        check("abandon_owner", owner, 0);
        bus_busy = '0;
    endtask

    // Scoreboard monitor: every new grant must match the oldest prediction.
    always @(negedge clk) begin
        if (!reset) begin
            prev_grant <= '0;
        end else begin
            if ((abtr_grant != '0) && (prev_grant == '0)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", abtr_grant, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("grant_vector", abtr_grant, 1 << mon_e);
                    check("grant_owner", owner, mon_e);
                    check("grant_owner_valid", owner_valid, 1);
                end
            end
            prev_grant <= abtr_grant;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got %0t, expected finish earlier", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int w;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_grant", abtr_grant, 0);
        check("reset_owner", owner, 0);
        check("reset_owner_valid", owner_valid, 0);
        check("reset_timeout", grant_timeout, 0);

        // Fairness: all four requesting, each holds busy three cycles
        abtr_reqcyc = 4'hF;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_grant(w);
            check("fair_order", w, i % NUM_REQ);
            claim(w, 0, 3, 4'hF);
        end

        // Single requester, busy right after grant, held five cycles
        abtr_reqcyc = 4'b0010;
        expect_grant(w);
        check("single_winner", w, 1);
        claim(w, 0, 5, 4'b0000);

        // Abandon by requester 3 with requester 1 pending
        abtr_reqcyc = 4'b1010;
        expect_grant(w);
        check("abandon_first", w, 3);
        abandon(w, 1, 4'b1010);
        expect_grant(w);
        check("abandon_next", w, 1);
        claim(w, 0, 2, 4'b0000);

        // Stray busy from a non-owner while owner 1 releases
        abtr_reqcyc = 4'b0010;
        expect_grant(w);
        bus_busy = 4'b0110;
        abtr_reqcyc = 4'b0000;
        step();
        check("stray_owned_owner", owner, 1);
        bus_busy = 4'b0100;
        step();
        check("stray_release_valid", owner_valid, 0);
        check("stray_release_owner", owner, 0);
        step();
        check("stray_not_assumed", owner_valid, 0);
        bus_busy = '0;
        m_ptr = 2;

        // Randomized transactions
        for (int t = 0; t < 80; t++) begin
            if (abtr_reqcyc == '0) begin
                step();
                check("idle_no_owner", owner_valid, 0);
                abtr_reqcyc = NUM_REQ'($urandom_range(1, 15));
            end
            expect_grant(w);
            if ($urandom_range(0, 3) == 0) begin
                abandon(w, $urandom_range(0, 2), NUM_REQ'($urandom));
            end else begin
                claim(w, $urandom_range(0, 2), $urandom_range(1, 4), NUM_REQ'($urandom));
            end
        end

        // Reset in the middle of an OWNED transaction by requester 2
        abtr_reqcyc = 4'b0100;
        expect_grant(w);
        claim(w, 0, 2, 4'b0000);
        abtr_reqcyc = 4'b0100;
        expect_grant(w);
        bus_busy = 4'b0100;
        step();
        check("pre_reset_owner", owner, 2);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_grant", abtr_grant, 0);
        check("midreset_owner", owner, 0);
        check("midreset_owner_valid", owner_valid, 0);
        check("midreset_timeout", grant_timeout, 0);
        bus_busy = '0;
        abtr_reqcyc = 4'hF;
        m_ptr = 0;
        @(negedge clk);
        reset = 1'b1;
        expect_grant(w);
        check("post_reset_winner", w, 0);
        claim(w, 0, 1, 4'b0000);

`ifdef BUS_ARB_WATCHDOG_EN
        // Unclaimed grant to 0 is revoked after GRANT_TIMEOUT cycles
        abtr_reqcyc = 4'b0001;
        expect_grant(w);
        check("wd_winner", w, 0);
        for (int i = 1; i < GRANT_TIMEOUT; i++) begin
            step();
            check("wd_grant_held", abtr_grant, 1);
            check("wd_no_pulse", grant_timeout, 0);
        end
        step();
        check("wd_pulse", grant_timeout, 1);
        check("wd_grant_cleared", abtr_grant, 0);
        check("wd_idle", owner_valid, 0);
        abtr_reqcyc = 4'b0011;
        m_ptr = 1;
        expect_grant(w);
        check("wd_pulse_single", grant_timeout, 0);
        check("wd_next_winner", w, 1);
        claim(w, 0, 1, 4'b0000);
`endif

        step();
        step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
